// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in serial-out serializer.
//   state_e         : FSM state encoding (IDLE, SHIFT)
//   DEFAULT_N       : default word width in bits
//   cnt_width()     : width of the bit counter for an N-bit word
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEFAULT_N = 4;

  // Counter must hold 0..N-1; a one-bit counter is the floor.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter, LSB first, one bit per enabled clock.
// Pairs with a right-shifting SIPO of the same width: after N shifts the
// receiver holds the transmitted word unchanged.
//
// Ports:
//   clk         clock, all state updates on posedge
//   rst         asynchronous active-high reset
//   din[N-1:0]  parallel word offered by the producer
//   load_valid  producer offers din this cycle
//   load_ready  serializer accepts din this cycle
//   shift_en    link enable; low stalls the current bit on so
//   so          serial data out
//   so_valid    so carries a valid bit
//   so_last     so carries bit N-1 of the current word
//
// Handshake: a word is accepted on a posedge where load_valid && load_ready.
// The producer holds din and load_valid until accepted; din is sampled only
// at the accepting edge. load_ready is the only output with a combinational
// input dependency (shift_en), which allows a new word to be taken on the
// same edge that consumes the last bit, giving gapless back-to-back words.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         shift_en,
  output logic         so,
  output logic         so_valid,
  output logic         so_last
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  state_e        state_q, state_d;
  logic [N-1:0]  sreg_q, sreg_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic on_last;
  logic accept;

  assign on_last    = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign load_ready = (state_q == IDLE) || (on_last && shift_en);
  assign accept     = load_valid && load_ready;

  assign so       = sreg_q[0];
  assign so_valid = (state_q == SHIFT);
  assign so_last  = on_last;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d  = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (cnt_q == LAST_CNT) begin
            if (accept) begin
              sreg_d = din;
              cnt_d  = '0;
            end else begin
              // Clearing sreg keeps so at 0 while idle.
              sreg_d  = '0;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else begin
            sreg_d = sreg_q >> 1;
            cnt_d  = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        sreg_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
